coin_bank_tx: RTL and testbench

COIN_BANK_TX -- requirements
Module: coin_bank_tx

---
 rtl/coin_bank_tx.sv | 206 ++++++++++++++++++++
 tb/tb_coin_bank_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_bank_tx.sv
// coin_bank_tx: coin accumulator with a UART frame transmitter.
//
// Each coin_in bit and send_in go through a 2-flop synchroniser and then
// their own debouncer. A debounced coin rising edge adds that channel's value
// to total. The add saturates, and saturation sets a sticky overflow flag.
// A debounced send rising edge, accepted only while idle, snapshots total.
// It then transmits the 8N1 frame 0xA5, total[15:8], total[7:0].
// The frame uses the zero-extended 16-bit total.
//
// Optional feature: define COIN_BANK_CHECKSUM_EN to append a fourth byte.
// That byte is 0xA5 ^ high ^ low.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   coin_in   raw coin buttons, one per channel (active-high, async)
//   send_in   raw send button (active-high, async)
//   clear_in  synchronous clear of total/overflow (not debounced)
//   total     accumulated total
//   overflow  sticky saturation flag
//   busy      high while a frame is being transmitted
//   tx        UART serial output, idle high
module coin_bank_tx #(
    parameter int                     NUM_COINS       = 4,
    parameter logic [8*NUM_COINS-1:0] COIN_VALUES     = {8'd10, 8'd5, 8'd2, 8'd1},
    parameter int                     DEBOUNCE_CYCLES = 400000,
    parameter int                     TOTAL_W         = 16,
    parameter int                     CLKS_PER_BIT    = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_COINS-1:0] coin_in,
    input  logic                 send_in,
    input  logic                 clear_in,
    output logic [TOTAL_W-1:0]   total,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx
);

    // Channel NUM_COINS is the send button; the others are coins.
    localparam int NCH   = NUM_COINS + 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CLK_W = $clog2(CLKS_PER_BIT + 1);
`ifdef COIN_BANK_CHECKSUM_EN
    localparam int NUM_BYTES = 4;
`else
    localparam int NUM_BYTES = 3;
`endif
    localparam logic [16:0] TOTAL_MAX = 17'((17'd1 << TOTAL_W) - 17'd1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [NCH-1:0]   raw, sync1, sync2, level, rise;
    logic [CNT_W-1:0] db_cnt [NCH];

    assign raw = {send_in, coin_in};

    // Synchronisers and debouncers. 'rise' is a one-cycle pulse registered
    // in the same cycle the stable level goes 0->1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            rise  <= '0;
            for (int unsigned i = 0; i < NCH; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= sync2[i];
                        rise[i]   <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Sum of all coin edges this cycle, then the saturating add.
    logic [10:0] add_sum;
    logic [16:0] sum_ext;
    logic        saturate;

    always_comb begin
        add_sum = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (rise[i]) add_sum = add_sum + 11'(COIN_VALUES[8*i +: 8]);
        end
        sum_ext  = 17'(total) + 17'(add_sum);
        saturate = (sum_ext > TOTAL_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst || clear_in) begin
            total    <= '0;
            overflow <= 1'b0;
        end else if (saturate) begin
            total    <= '1;
            overflow <= 1'b1;
        end else begin
            total    <= sum_ext[TOTAL_W-1:0];
        end
    end

    // UART transmitter
    state_t           state;
    logic [CLK_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [15:0]      snap;
    logic [7:0]       cur_byte;
    logic             bit_end;
    logic             send_edge;

    assign send_edge = rise[NUM_COINS];
    assign bit_end   = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = 8'hA5;
            2'd1:    cur_byte = snap[15:8];
            2'd2:    cur_byte = snap[7:0];
`ifdef COIN_BANK_CHECKSUM_EN
            2'd3:    cur_byte = 8'hA5 ^ snap[15:8] ^ snap[7:0];
`endif
            default: cur_byte = '0;
        endcase
    end

    // tx/busy are driven one cycle ahead so that they are registered outputs.
    // Each state therefore lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            snap     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (send_edge) begin
                        state    <= START;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        snap     <= 16'(total);
                        byte_idx <= '0;
                        clk_cnt  <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= cur_byte[0];
                        bit_idx <= '0;
                        clk_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx == 2'(NUM_BYTES - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= START;
                            tx       <= 1'b0;
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_bank_tx.sv
// Testbench for coin_bank_tx.
// It uses DEBOUNCE_CYCLES=16, CLKS_PER_BIT=4 and TOTAL_W=9.
// The 9-bit total lets saturation be reached.
module tb_coin_bank_tx;

    localparam int DB   = 16;
    localparam int CPB  = 4;
    localparam int TW   = 9;
    localparam int MAXV = (1 << TW) - 1;
`ifdef COIN_BANK_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int BITS = 10 * CPB;
    localparam int LEN  = NB * BITS + 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    coin_in = '0;
    logic          send_in = 1'b0;
    logic          clear_in = 1'b0;
    logic [TW-1:0] total;
    logic          overflow, busy, tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coin_bank_tx #(
        .NUM_COINS(4),
        .COIN_VALUES({8'd10, 8'd5, 8'd2, 8'd1}),
        .DEBOUNCE_CYCLES(DB),
        .TOTAL_W(TW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .send_in(send_in),
        .clear_in(clear_in), .total(total), .overflow(overflow),
        .busy(busy), .tx(tx)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Count changes of total (for single-update checks).
    int            n_upd = 0;
    int            last_delta = 0;
    logic [TW-1:0] prev_total = '0;
    always @(negedge clk) begin
        if (total !== prev_total) begin
            n_upd++;
            last_delta = int'(total) - int'(prev_total);
        end
        prev_total = total;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: total is the sum of accepted coin values.
    // The sum saturates at MAXV, and overflow is sticky.
    int   m_total = 0;
    logic m_ovf   = 1'b0;

    function automatic int coin_val(input logic [3:0] m);
        int s = 0;
        if (m[0]) s += 1;
        if (m[1]) s += 2;
        if (m[2]) s += 5;
        if (m[3]) s += 10;
        return s;
    endfunction

    task automatic model_add(input int s);
        if (m_total + s > MAXV) begin
            m_total = MAXV;
            m_ovf   = 1'b1;
        end else begin
            m_total += s;
        end
    endtask

    task automatic check_model(input string nm);
        check({nm, ".total"}, 32'(total), m_total);
        check({nm, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic press(input logic [3:0] m, input int hold, input int rel);
        @(negedge clk);
        coin_in = m;
        repeat (hold) @(negedge clk);
        coin_in = '0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        @(negedge clk);
    endtask

    // Presses send and captures the frame, then checks it against exp_val.
    // inject: a second send press and a ch0 coin are made mid-frame.
    // abort_at >= 0: rst is asserted at that bit-sample index instead.
    task automatic run_frame(input string nm, input int exp_val, input bit inject, input int abort_at);
        logic       txlog [LEN];
        logic       bzlog [LEN];
        logic [7:0] eb [4];
        logic [7:0] got;
        int         wait_cnt;
        int         bcount;
        eb[0] = 8'hA5;
        eb[1] = 8'(exp_val >> 8);
        eb[2] = 8'(exp_val);
        eb[3] = eb[0] ^ eb[1] ^ eb[2];
        @(negedge clk);
        send_in  = 1'b1;
        wait_cnt = 0;
        while (busy !== 1'b1 && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (busy !== 1'b1) begin
            check({nm, ".busy_rise"}, 32'(busy), 1);
            send_in = 1'b0;
            return;
        end
        check({nm, ".tx_falls_with_busy"}, 32'(tx), 0);
        for (int i = 0; i < LEN; i++) begin
            txlog[i] = tx;
            bzlog[i] = busy;
            if (i == 5) send_in = 1'b0;
            if (inject && i == 30) begin send_in = 1'b1; coin_in = 4'b0001; end
            if (inject && i == 60) begin send_in = 1'b0; coin_in = '0; end
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check({nm, ".abort_tx"}, 32'(tx), 1);
                check({nm, ".abort_busy"}, 32'(busy), 0);
                check({nm, ".abort_total"}, 32'(total), 0);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < 8; j++) got[j] = txlog[b*BITS + CPB*(j+1) + CPB/2];
            check($sformatf("%s.start%0d", nm, b), 32'(txlog[b*BITS + CPB/2]), 0);
            check($sformatf("%s.byte%0d", nm, b), 32'(got), 32'(eb[b]));
            check($sformatf("%s.stop%0d", nm, b), 32'(txlog[b*BITS + 9*CPB + CPB/2]), 1);
        end
        bcount = 0;
        for (int i = 0; i < LEN; i++) if (bzlog[i] === 1'b1) bcount++;
        check({nm, ".busy_cycles"}, bcount, NB * BITS);
    endtask

    typedef struct {
        logic [3:0] mask;
        int         hold;
        logic       clr;
        int         exp_total;
        logic       exp_ovf;
        int         exp_upd;    // expected number of total changes, -1 = don't care
        int         exp_delta;
    } vec_t;

    vec_t tbl [9];
    int   seen_busy;
    int   r;
    logic [3:0] m;

    initial begin
        tbl[0] = '{4'b1000, 40, 1'b0, 10, 1'b0,  1, 10};
        tbl[1] = '{4'b0100, 40, 1'b0, 15, 1'b0,  1,  5};
        tbl[2] = '{4'b0010, 40, 1'b0, 17, 1'b0,  1,  2};
        tbl[3] = '{4'b0001, 40, 1'b0, 18, 1'b0,  1,  1};
        tbl[4] = '{4'b0001, 10, 1'b0, 18, 1'b0,  0,  0};  // glitch shorter than debounce
        tbl[5] = '{4'b0011, 40, 1'b0, 21, 1'b0,  1,  3};  // simultaneous edges
        tbl[6] = '{4'b0000,  0, 1'b1,  0, 1'b0, -1,  0};  // clear
        tbl[7] = '{4'b1000, 40, 1'b0, 10, 1'b0,  1, 10};
        tbl[8] = '{4'b0111, 40, 1'b0, 18, 1'b0,  1,  8};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.total", 32'(total), 0);
        check("reset.overflow", 32'(overflow), 0);
        check("reset.busy", 32'(busy), 0);
        check("reset.tx", 32'(tx), 1);

        // Directed table
        for (int k = 0; k < 9; k++) begin
            n_upd = 0;
            if (tbl[k].clr) do_clear();
            else press(tbl[k].mask, tbl[k].hold, 40);
            check($sformatf("tbl%0d.total", k), 32'(total), tbl[k].exp_total);
            check($sformatf("tbl%0d.overflow", k), 32'(overflow), 32'(tbl[k].exp_ovf));
            if (tbl[k].exp_upd >= 0)
                check($sformatf("tbl%0d.updates", k), n_upd, tbl[k].exp_upd);
            if (tbl[k].exp_upd == 1)
                check($sformatf("tbl%0d.delta", k), last_delta, tbl[k].exp_delta);
        end
        m_total = 18;
        m_ovf   = 1'b0;

        // Frame of 18 with an ignored second send and a mid-frame coin.
        run_frame("frame18", 18, 1'b1, -1);
        seen_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy === 1'b1) seen_busy++;
        end
        check("frame18.no_second_frame", seen_busy, 0);
        model_add(1);
        check_model("frame18.after");

        // Reset during the data bits of the second byte.
        run_frame("abort", 19, 1'b0, BITS + CPB + 2*CPB + 2);
        m_total = 0;
        m_ovf   = 1'b0;
        repeat (30) @(negedge clk);
        run_frame("frame0", 0, 1'b0, -1);
        repeat (10) @(negedge clk);

        // Coin held through reset release counts once.
        @(negedge clk);
        coin_in = 4'b0010;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("held_rst.total", 32'(total), 2);
        coin_in = '0;
        repeat (40) @(negedge clk);
        check("held_rst.total_after_release", 32'(total), 2);
        m_total = 2;

        // Saturation at 2^9-1
        do_clear();
        m_total = 0;
        for (int k = 0; k < 50; k++) begin
            press(4'b1000, 24, 24);
            model_add(10);
        end
        press(4'b0100, 24, 24);
        model_add(5);
        check("sat.total505", 32'(total), 505);
        check_model("sat.pre");
        press(4'b1000, 24, 24);
        model_add(10);
        check("sat.total511", 32'(total), 511);
        check("sat.overflow", 32'(overflow), 1);
        do_clear();
        m_total = 0;
        m_ovf   = 1'b0;
        check("sat.clear_total", 32'(total), 0);
        check("sat.clear_overflow", 32'(overflow), 0);

        // Clear coincident with a coin edge drops the coin.
        // The add lands 3+DB cycles after the input rises.
        @(negedge clk);
        coin_in = 4'b0100;
        repeat (DB + 1) @(negedge clk);
        clear_in = 1'b1;
        repeat (2) @(negedge clk);
        clear_in = 1'b0;
        repeat (20) @(negedge clk);
        coin_in = '0;
        repeat (30) @(negedge clk);
        check_model("clear_wins");

        // Random coins, glitches and clears
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            m = 4'($urandom_range(1, 15));
            if (r <= 5) begin
                press(m, $urandom_range(22, 30), $urandom_range(22, 30));
                model_add(coin_val(m));
            end else if (r <= 8) begin
                press(m, $urandom_range(1, DB - 1), 25);
            end else begin
                do_clear();
                m_total = 0;
                m_ovf   = 1'b0;
            end
            check_model($sformatf("rand%0d", k));
        end

        // Frame of whatever total the random run left.
        run_frame("frame_rand", m_total, 1'b0, -1);
        repeat (10) @(negedge clk);
        check_model("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
